// File: rtl/tdm_demux4_if.sv
// Bus bundle for the 1-to-4 TDM demultiplexer.
// The master drives the input stream and controls. The slave (the demux) drives the channel outputs.
interface tdm_demux4_if #(
   parameter int WIDTH = 1
);
   logic             en;
   logic             mode;
   logic [1:0]       sel;
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_sync;
   logic [WIDTH-1:0] d0;
   logic [WIDTH-1:0] d1;
   logic [WIDTH-1:0] d2;
   logic [WIDTH-1:0] d3;
   logic [3:0]       vld;
   logic [1:0]       slot;
   logic             locked;
   logic             frame_done;
   logic             sync_err;

   modport master (
      output en, mode, sel, in_valid, in_data, in_sync,
      input  d0, d1, d2, d3, vld, slot, locked, frame_done, sync_err
   );

   modport slave (
      input  en, mode, sel, in_valid, in_data, in_sync,
      output d0, d1, d2, d3, vld, slot, locked, frame_done, sync_err
   );
endinterface

// File: rtl/tdm_demux4.sv
// 1-to-4 time-division demultiplexer: each word is steered into one of four registered channels.
// Steering comes from a sync-locked slot counter in auto mode, or from sel in manual mode.
module tdm_demux4 #(
   parameter int WIDTH = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   tdm_demux4_if.slave   bus
);
   typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

   state_t           state_reg, state_next;
   logic [1:0]       slot_reg, slot_next;
   logic [3:0]       vld_reg, vld_next;
   logic             frame_done_reg, frame_done_next;
   logic             sync_err_reg, sync_err_next;
   logic             wr_en;
   logic [1:0]       wr_ch;
   logic             acc;
   logic [WIDTH-1:0] d_reg [4];

   assign acc = bus.en & bus.in_valid;

   // Manual mode pins the auto FSM in HUNT every cycle, so a return to auto always re-hunts.
   always_comb begin
      state_next      = state_reg;
      slot_next       = slot_reg;
      wr_en           = 1'b0;
      wr_ch           = 2'd0;
      frame_done_next = 1'b0;
      sync_err_next   = 1'b0;
      if (bus.mode) begin
         state_next = HUNT;
         slot_next  = 2'd0;
         if (acc) begin
            wr_en = 1'b1;
            wr_ch = bus.sel;
         end
      end else if (acc) begin
         case (state_reg)
            HUNT: begin
               if (bus.in_sync) begin
                  wr_en      = 1'b1;
                  wr_ch      = 2'd0;
                  slot_next  = 2'd1;
                  state_next = LOCKED;
               end
            end
            LOCKED: begin
               wr_en = 1'b1;
               if (bus.in_sync) begin
                  wr_ch         = 2'd0;
                  slot_next     = 2'd1;
                  sync_err_next = (slot_reg != 2'd0);
               end else begin
                  wr_ch           = slot_reg;
                  slot_next       = slot_reg + 2'd1;
                  frame_done_next = (slot_reg == 2'd3);
               end
            end
            default: state_next = HUNT;
         endcase
      end
      vld_next = wr_en ? (4'b0001 << wr_ch) : 4'b0000;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg      <= HUNT;
         slot_reg       <= 2'd0;
         vld_reg        <= 4'b0000;
         frame_done_reg <= 1'b0;
         sync_err_reg   <= 1'b0;
      end else begin
         state_reg      <= state_next;
         slot_reg       <= slot_next;
         vld_reg        <= vld_next;
         frame_done_reg <= frame_done_next;
         sync_err_reg   <= sync_err_next;
      end
   end

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_chan
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               d_reg[gi] <= '0;
            end else if (vld_next[gi]) begin
               d_reg[gi] <= bus.in_data;
            end
         end
      end
   endgenerate

   assign bus.d0         = d_reg[0];
   assign bus.d1         = d_reg[1];
   assign bus.d2         = d_reg[2];
   assign bus.d3         = d_reg[3];
   assign bus.vld        = vld_reg;
   assign bus.slot       = slot_reg;
   assign bus.locked     = (state_reg == LOCKED);
   assign bus.frame_done = frame_done_reg;
   assign bus.sync_err   = sync_err_reg;
endmodule

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
- 1-to-4 time-division demultiplexer; the receive-side counterpart of the team's 4:1 mux.
- Accepts a stream of words, one word per slot and four slots per frame, with a sync marker on slot 0.
- Steers each word into one of four registered output channels and raises a per-channel valid pulse.
- A manual mode steers by an explicit select, which gives a direct inverse of the mux for bench pairing.

Parameters:
WIDTH, 1, data word width per channel (1 matches the existing 1-bit mux data lines)

Ports:
clk  input  1  single clock; all logic on rising edge
rst_n  input  1  reset, synchronous, active-low
en  input  1  block enable; low = accept nothing, hold all state
mode  input  1  0 = auto (slot counter), 1 = manual (sel steers)
sel  input  2  manual-mode channel select (S2:S1 order, sel[1]=S2)
in_valid  input  1  in_data/in_sync qualified this cycle
in_data  input  WIDTH  incoming word
in_sync  input  1  marks current word as slot 0 (auto mode only)
d0  output  WIDTH  channel 0 registered data
d1  output  WIDTH  channel 1 registered data
d2  output  WIDTH  channel 2 registered data
d3  output  WIDTH  channel 3 registered data
vld  output  4  one-hot, 1-cycle pulse; vld[i] = di updated this cycle
slot  output  2  next expected slot (auto mode)
locked  output  1  high in LOCKED state
frame_done  output  1  1-cycle pulse when slot 3 is written in auto mode
sync_err  output  1  1-cycle pulse on misaligned sync

Behaviour:
- Reset (rst_n=0 sampled at clk edge): d0..d3=0, vld=0, slot=0, locked=0, frame_done=0, sync_err=0, state=HUNT. Reset overrides all inputs, including mid-frame.
- Accept condition: acc = en & in_valid. When en=0: no state change, d* hold, pulses low.
- Latency: accepted word appears on di with vld[i]=1 on the clock edge after it is sampled (1 cycle). At most one vld bit is set per cycle.
- Pulses vld, frame_done and sync_err last exactly one cycle and are 0 otherwise.
- Manual mode (mode=1):
  - On acc: d[sel] <= in_data; vld[sel] pulses.
  - in_sync is ignored; slot, locked and frame_done are not driven.
  - State is forced to HUNT with slot=0, so locked=0.
- Auto mode, state HUNT:
  - acc with in_sync=0: word dropped, no vld.
  - acc with in_sync=1: d0 <= in_data, vld[0] pulses, slot <= 1, state <= LOCKED.
- Auto mode, state LOCKED:
  - acc with in_sync=0: d[slot] <= in_data; vld[slot] pulses; slot <= slot+1 (wraps 3->0).
  - When the written slot is 3: frame_done pulses on the same edge as vld[3].
  - acc with in_sync=1 and slot=0: normal slot-0 write; no error.
  - acc with in_sync=1 and slot!=0: sync_err pulses; word is written to d0 (vld[0]); slot <= 1; remains LOCKED (realign; the partial frame is abandoned and frame_done is not pulsed).
- Mode change 0->1 or 1->0: takes effect on the same cycle. A 1->0 change always starts in HUNT.
- Words written to slots 0-2 only complete a frame if slot 3 is subsequently written; the block does no buffering beyond the channel registers.

Test Plan:
- Reset mid-frame: LOCKED with slot=2, drive rst_n=0 for one edge -> d0..d3=0, slot=0, locked=0, vld=0 on the next cycle.
- Auto lock and frame:
  - Stimulus: WIDTH=4, mode=0, en=1; words A(sync=1), B, C, D in consecutive cycles.
  - Response: d0=A, d1=B, d2=C, d3=D, each 1 cycle after its input; vld sequence 0001, 0010, 0100, 1000; frame_done with the last; locked=1 from the first.
- HUNT drop: words 5, 6 with sync=0, then 7 with sync=1 -> no vld for 5 and 6; d0=7, vld=0001, slot=1.
- Misaligned sync: LOCKED at slot=2, word 9 with in_sync=1 -> sync_err=1, d0=9, vld=0001, slot=1; no frame_done.
- Manual mode, inverse of the mux:
  - Stimulus: mode=1, in_data=1, sel=00, 11, 01, 10 for 250 cycles each.
  - Response: vld pulses on 0001, 1000, 0010, 0100 respectively; only the selected di changes.
- Enable gating: en=0 with in_valid=1 for 3 cycles -> vld=0, d* and slot unchanged; en=1 resumes at the same slot.
